// File: rtl/stack_pkg.sv
// Shared op encoding for the operand stack and its controller.
// Latency: n/a (constants only).
// Backpressure: n/a.
package stack_pkg;

  localparam int OP_W = 3;

  typedef logic [OP_W-1:0] op_t;

  localparam op_t STK_NOP    = 3'd0;
  localparam op_t STK_PUSH   = 3'd1;
  localparam op_t STK_POP    = 3'd2;
  localparam op_t STK_DUP    = 3'd3;
  localparam op_t STK_SWAP   = 3'd4;
  localparam op_t STK_REPL   = 3'd5;
  localparam op_t STK_REDUCE = 3'd6;
  localparam op_t STK_CLEAR  = 3'd7;

endpackage

// File: rtl/stack_regfile.sv
// DEPTH x WIDTH stack storage: three async read ports, a main write port and an exchange port.
// Latency: writes land on the rising edge; reads are combinational from registered storage.
// Backpressure: none; every enabled write is taken.
module stack_regfile #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             xwe,
  input  logic [AW-1:0]    xaddr,
  input  logic [WIDTH-1:0] xdata,
  input  logic [AW-1:0]    raddr_top,
  input  logic [AW-1:0]    raddr_sec,
  input  logic [AW-1:0]    raddr_dup,
  output logic [WIDTH-1:0] rdata_top,
  output logic [WIDTH-1:0] rdata_sec,
  output logic [WIDTH-1:0] rdata_dup
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage is deliberately not reset; the top level masks invalid entries.
  // The exchange port is only used by SWAP, which never targets the same entry as the main port.
  always_ff @(posedge clk) begin
    if (we)  mem[waddr] <= wdata;
    if (xwe) mem[xaddr] <= xdata;
  end

  assign rdata_top = mem[raddr_top];
  assign rdata_sec = mem[raddr_sec];
  assign rdata_dup = mem[raddr_dup];

endmodule

// File: rtl/param_stack_unit.sv
// Parametrised operand stack: one push/pop/dup/swap/repl/reduce/clear op per clock, sticky error flags.
// Latency: op sampled on the rising edge; top/second/count/op_ok reflect it right after that edge.
// Backpressure: none; illegal ops are rejected (no state change, op_ok=0) and flagged.
module param_stack_unit
  import stack_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int IDX_W = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [OP_W-1:0]            op,
  input  logic [WIDTH-1:0]           din,
  input  logic [IDX_W-1:0]           dup_idx,
  output logic [WIDTH-1:0]           top,
  output logic [WIDTH-1:0]           second,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full,
  output logic                       overflow,
  output logic                       underflow,
  output logic                       op_ok
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  // Index arithmetic width wide enough for both count and dup_idx.
  localparam int XW = (CW > IDX_W) ? CW : IDX_W;

  logic [CW-1:0]    cnt, cnt_nxt;
  logic [XW-1:0]    cnt_x, idx_x;
  logic [AW-1:0]    a_top, a_sec, a_dup, a_new;
  logic [WIDTH-1:0] rd_top, rd_sec, rd_dup;
  logic             we, xwe, ok, set_ovf, set_unf, clr;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;

  assign cnt_x = XW'(cnt);
  assign idx_x = XW'(dup_idx);
  assign a_new = AW'(cnt);
  assign a_top = AW'(cnt - CW'(1));
  assign a_sec = AW'(cnt - CW'(2));
  assign a_dup = AW'(cnt_x - XW'(1) - idx_x);

  stack_regfile #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_rf (
    .clk       (clk),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .xwe       (xwe),
    .xaddr     (a_sec),
    .xdata     (rd_top),
    .raddr_top (a_top),
    .raddr_sec (a_sec),
    .raddr_dup (a_dup),
    .rdata_top (rd_top),
    .rdata_sec (rd_sec),
    .rdata_dup (rd_dup)
  );

  assign count  = cnt;
  assign empty  = (cnt == '0);
  assign full   = (cnt == CW'(DEPTH));
  assign top    = (cnt != '0)     ? rd_top : '0;
  assign second = (cnt >= CW'(2)) ? rd_sec : '0;

  // Legality decode, error classification and the write mux; all reads use pre-op storage.
  always_comb begin
    ok      = 1'b1;
    set_ovf = 1'b0;
    set_unf = 1'b0;
    clr     = 1'b0;
    we      = 1'b0;
    xwe     = 1'b0;
    waddr   = a_new;
    wdata   = din;
    cnt_nxt = cnt;
    case (op)
      STK_PUSH: begin
        if (full) begin
          ok = 1'b0; set_ovf = 1'b1;
        end else begin
          we = 1'b1; cnt_nxt = cnt + CW'(1);
        end
      end
      STK_POP: begin
        if (empty) begin
          ok = 1'b0; set_unf = 1'b1;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      STK_DUP: begin
        // Reaching below the bottom is an underflow even when the stack is also full.
        if (cnt_x <= idx_x) begin
          ok = 1'b0; set_unf = 1'b1;
        end else if (full) begin
          ok = 1'b0; set_ovf = 1'b1;
        end else begin
          we = 1'b1; wdata = rd_dup; cnt_nxt = cnt + CW'(1);
        end
      end
      STK_SWAP: begin
        if (cnt < CW'(2)) begin
          ok = 1'b0; set_unf = 1'b1;
        end else begin
          we = 1'b1; waddr = a_top; wdata = rd_sec; xwe = 1'b1;
        end
      end
      STK_REPL: begin
        if (empty) begin
          ok = 1'b0; set_unf = 1'b1;
        end else begin
          we = 1'b1; waddr = a_top;
        end
      end
      STK_REDUCE: begin
        if (cnt < CW'(2)) begin
          ok = 1'b0; set_unf = 1'b1;
        end else begin
          we = 1'b1; waddr = a_sec; cnt_nxt = cnt - CW'(1);
        end
      end
      STK_CLEAR: begin
        clr = 1'b1; cnt_nxt = '0;
      end
      default: ;
    endcase
  end

  // Occupancy, op status and sticky flags; CLEAR wins over flag retention.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      op_ok     <= 1'b1;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      op_ok     <= ok;
      overflow  <= clr ? 1'b0 : (overflow  | set_ovf);
      underflow <= clr ? 1'b0 : (underflow | set_unf);
    end
  end

endmodule

// File: tb/tb_param_stack_unit.sv
// Directed scoreboard bench for param_stack_unit.
// Latency: expectations are checked one edge after the op is driven.
// Backpressure: n/a.
module tb_param_stack_unit;
  import stack_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  op = STK_NOP;
  logic [15:0] din = '0;
  logic [3:0]  dup_idx = '0;
  logic [15:0] top, second;
  logic [4:0]  count;
  logic        empty, full, overflow, underflow, op_ok;

  param_stack_unit #(.WIDTH(16), .DEPTH(16), .IDX_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .din       (din),
    .dup_idx   (dup_idx),
    .top       (top),
    .second    (second),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow),
    .op_ok     (op_ok)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    int          id;
    logic [15:0] top;
    logic [15:0] second;
    logic [4:0]  count;
    logic        empty;
    logic        full;
    logic        ovf;
    logic        unf;
    logic        ok;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s (vec %0d) actual=%0h required=%0h", nm, id, act, req);
    end
  endtask

  task automatic drive(input logic [2:0] o, input logic [15:0] d, input logic [3:0] k);
    @(negedge clk);
    op = o; din = d; dup_idx = k;
  endtask

  // Queue the hand-computed result of the op just driven.
  task automatic want(input int id, input logic [15:0] t, input logic [15:0] s, input logic [4:0] c,
                      input logic e, input logic f, input logic ov, input logic un, input logic ok);
    exp_t x;
    x.tag = cyc; x.id = id; x.top = t; x.second = s; x.count = c;
    x.empty = e; x.full = f; x.ovf = ov; x.unf = un; x.ok = ok;
    q.push_back(x);
  endtask

  // Monitor: after each edge, compare the expectation queued for the op that edge executed.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      while (q.size() > 0 && q[0].tag < cyc - 1) begin
        x = q.pop_front();
        chk("stale_expectation", x.id, 32'(x.tag), 32'(cyc - 1));
      end
      if (q.size() > 0 && q[0].tag == cyc - 1) begin
        x = q.pop_front();
        chk("top",       x.id, 32'(top),       32'(x.top));
        chk("second",    x.id, 32'(second),    32'(x.second));
        chk("count",     x.id, 32'(count),     32'(x.count));
        chk("empty",     x.id, 32'(empty),     32'(x.empty));
        chk("full",      x.id, 32'(full),      32'(x.full));
        chk("overflow",  x.id, 32'(overflow),  32'(x.ovf));
        chk("underflow", x.id, 32'(underflow), 32'(x.unf));
        chk("op_ok",     x.id, 32'(op_ok),     32'(x.ok));
      end
    end
  end

  task automatic chk_reset_state(input int id);
    chk("rst_count", id, 32'(count),     32'd0);
    chk("rst_empty", id, 32'(empty),     32'd1);
    chk("rst_full",  id, 32'(full),      32'd0);
    chk("rst_ovf",   id, 32'(overflow),  32'd0);
    chk("rst_unf",   id, 32'(underflow), 32'd0);
    chk("rst_ok",    id, 32'(op_ok),     32'd1);
    chk("rst_top",   id, 32'(top),       32'd0);
    chk("rst_sec",   id, 32'(second),    32'd0);
  endtask

  initial begin
    // Power-on reset
    repeat (2) @(posedge clk);
    #1 chk_reset_state(0);
    @(negedge clk); reset = 1'b0;

    // Eight pushes, then reset while further pushes keep being issued
    for (int i = 0; i < 8; i++) drive(STK_PUSH, 16'(i + 1), 4'd0);
    want(1, 16'd8, 16'd7, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk); reset = 1'b1;
    #1 chk_reset_state(2);
    repeat (2) @(posedge clk);
    #1 chk_reset_state(3);
    @(negedge clk); reset = 1'b0; op = STK_NOP;

    drive(STK_PUSH,   16'd8,  4'd0); want(10, 16'd8,  16'd0,  5'd1, 0, 0, 0, 0, 1);
    drive(STK_PUSH,   16'd17, 4'd0); want(11, 16'd17, 16'd8,  5'd2, 0, 0, 0, 0, 1);
    drive(STK_REDUCE, 16'd25, 4'd0); want(12, 16'd25, 16'd0,  5'd1, 0, 0, 0, 0, 1);
    drive(STK_POP,    16'd0,  4'd0); want(13, 16'd0,  16'd0,  5'd0, 1, 0, 0, 0, 1);
    drive(STK_PUSH,   16'd43, 4'd0); want(14, 16'd43, 16'd0,  5'd1, 0, 0, 0, 0, 1);
    drive(STK_PUSH,   16'd0,  4'd0); want(15, 16'd0,  16'd43, 5'd2, 0, 0, 0, 0, 1);
    drive(STK_DUP,    16'd0,  4'd1); want(16, 16'd43, 16'd0,  5'd3, 0, 0, 0, 0, 1);
    drive(STK_SWAP,   16'd0,  4'd0); want(17, 16'd0,  16'd43, 5'd3, 0, 0, 0, 0, 1);
    drive(STK_CLEAR,  16'd0,  4'd0); want(18, 16'd0,  16'd0,  5'd0, 1, 0, 0, 0, 1);

    // Fill to DEPTH with 100..115, then overflow attempts
    for (int i = 0; i < 16; i++) drive(STK_PUSH, 16'(100 + i), 4'd0);
    want(20, 16'd115, 16'd114, 5'd16, 0, 1, 0, 0, 1);
    drive(STK_PUSH,  16'd5, 4'd0); want(21, 16'd115, 16'd114, 5'd16, 0, 1, 1, 0, 0);
    drive(STK_DUP,   16'd0, 4'd3); want(22, 16'd115, 16'd114, 5'd16, 0, 1, 1, 0, 0);
    drive(STK_CLEAR, 16'd0, 4'd0); want(23, 16'd0,   16'd0,   5'd0,  1, 0, 0, 0, 1);

    // Underflow from empty, sticky across a good op, cleared by CLEAR
    drive(STK_POP,   16'd0, 4'd0); want(30, 16'd0, 16'd0, 5'd0, 1, 0, 0, 1, 0);
    drive(STK_PUSH,  16'd7, 4'd0); want(31, 16'd7, 16'd0, 5'd1, 0, 0, 0, 1, 1);
    drive(STK_CLEAR, 16'd0, 4'd0); want(32, 16'd0, 16'd0, 5'd0, 1, 0, 0, 0, 1);

    // DUP reaching below the bottom, REPL, SWAP, DUP 0
    drive(STK_PUSH, 16'd1, 4'd0);      want(40, 16'd1,    16'd0,    5'd1, 0, 0, 0, 0, 1);
    drive(STK_PUSH, 16'd2, 4'd0);      want(41, 16'd2,    16'd1,    5'd2, 0, 0, 0, 0, 1);
    drive(STK_DUP,  16'd0, 4'd2);      want(42, 16'd2,    16'd1,    5'd2, 0, 0, 0, 1, 0);
    drive(STK_REPL, 16'h1234, 4'd0);   want(43, 16'h1234, 16'd1,    5'd2, 0, 0, 0, 1, 1);
    drive(STK_SWAP, 16'd0, 4'd0);      want(44, 16'd1,    16'h1234, 5'd2, 0, 0, 0, 1, 1);
    drive(STK_DUP,  16'd0, 4'd0);      want(45, 16'd1,    16'd1,    5'd3, 0, 0, 0, 1, 1);
    drive(STK_NOP,  16'd0, 4'd0);      want(46, 16'd1,    16'd1,    5'd3, 0, 0, 0, 1, 1);

    // SWAP / REDUCE / REPL rejections
    drive(STK_CLEAR,  16'd0,  4'd0); want(50, 16'd0, 16'd0, 5'd0, 1, 0, 0, 0, 1);
    drive(STK_REPL,   16'd3,  4'd0); want(51, 16'd0, 16'd0, 5'd0, 1, 0, 0, 1, 0);
    drive(STK_PUSH,   16'd9,  4'd0); want(52, 16'd9, 16'd0, 5'd1, 0, 0, 0, 1, 1);
    drive(STK_SWAP,   16'd0,  4'd0); want(53, 16'd9, 16'd0, 5'd1, 0, 0, 0, 1, 0);
    drive(STK_REDUCE, 16'd77, 4'd0); want(54, 16'd9, 16'd0, 5'd1, 0, 0, 0, 1, 0);

    // Count 5, rejected DUP, then asynchronous reset mid-cycle
    for (int i = 0; i < 4; i++) drive(STK_PUSH, 16'(200 + i), 4'd0);
    want(60, 16'd203, 16'd202, 5'd5, 0, 0, 0, 1, 1);
    drive(STK_DUP, 16'd0, 4'd7); want(61, 16'd203, 16'd202, 5'd5, 0, 0, 0, 1, 0);
    drive(STK_PUSH, 16'd9, 4'd0);
    want(62, 16'd9, 16'd203, 5'd6, 0, 0, 0, 1, 1);
    @(posedge clk);
    #3 reset = 1'b1;
    #1 chk_reset_state(63);
    @(negedge clk); op = STK_NOP;
    @(negedge clk); reset = 1'b0;

    // Drain: every queued expectation must have been consumed
    repeat (3) @(posedge clk);
    #3;
    chk("scoreboard_drained", 99, 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

endmodule
